// File: rtl/score_evaluator.sv
// Score evaluator: latches five dice and a category on start, tallies face
// counts one die per cycle, then scores the selected category.
// Optional macro SCORE_BEST_EN adds a 12-cycle best-category search with
// best_cat/best_score outputs.
module score_evaluator (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] dice1,
  input  logic [2:0] dice2,
  input  logic [2:0] dice3,
  input  logic [2:0] dice4,
  input  logic [2:0] dice5,
  input  logic [3:0] cat_sel,
  output logic       busy,
  output logic       done,
  output logic [5:0] score,
  output logic       dice_err
`ifdef SCORE_BEST_EN
  ,
  output logic [3:0] best_cat,
  output logic [5:0] best_score
`endif
);

  typedef enum logic [1:0] {StIdle, StCount, StEval, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] die_q [5];
  logic [3:0] cat_q;
  logic [2:0] cnt_q [6];
  logic [2:0] idx_q;
  logic       err_q;
  logic [2:0] cur_face;
  logic [5:0] sel_score;

  // Score of one category from the face counters; categories 12..15 score 0.
  function automatic logic [5:0] cat_score(input logic [3:0] cat);
    logic [5:0] sum;
    logic [5:0] face_sc;
    logic [5:0] p;
    logic       four, three, two, five;
    sum     = '0;
    face_sc = '0;
    p       = '0;
    four    = 1'b0;
    three   = 1'b0;
    two     = 1'b0;
    five    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sum = sum + 6'(cnt_q[k]) * 6'(k + 1);
      if (cat == 4'(k)) face_sc = 6'(cnt_q[k]) * 6'(k + 1);
      p[k] = (cnt_q[k] != 3'd0);
      if (cnt_q[k] >= 3'd4) four = 1'b1;
      if (cnt_q[k] == 3'd3) three = 1'b1;
      if (cnt_q[k] == 3'd2) two = 1'b1;
      if (cnt_q[k] == 3'd5) five = 1'b1;
    end
    case (cat)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return face_sc;
      4'd6:    return sum;
      4'd7:    return four ? sum : 6'd0;
      4'd8:    return (three && two) ? sum : 6'd0;
      4'd9:    return ((&p[3:0]) || (&p[4:1]) || (&p[5:2])) ? 6'd15 : 6'd0;
      4'd10:   return ((&p[4:0]) || (&p[5:1])) ? 6'd30 : 6'd0;
      4'd11:   return five ? 6'd50 : 6'd0;
      default: return 6'd0;
    endcase
  endfunction

  // Face of the die being tallied this COUNT cycle.
  always_comb begin
    case (idx_q)
      3'd0:    cur_face = die_q[0];
      3'd1:    cur_face = die_q[1];
      3'd2:    cur_face = die_q[2];
      3'd3:    cur_face = die_q[3];
      default: cur_face = die_q[4];
    endcase
  end

  assign sel_score = err_q ? 6'd0 : cat_score(cat_q);

`ifdef SCORE_BEST_EN
  logic [3:0] eval_q;
  logic [3:0] run_cat_q;
  logic [5:0] run_score_q;
  logic [5:0] cand;
  logic       take;

  // Strict greater-than keeps the lowest index on ties.
  assign cand = cat_score(eval_q);
  assign take = (cand > run_score_q);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    case (state_q)
      StIdle:  if (start) state_d = StCount;
      StCount: if (idx_q == 3'd4) state_d = StEval;
`ifdef SCORE_BEST_EN
      StEval:  if (eval_q == 4'd11) state_d = StDone;
`else
      StEval:  state_d = StDone;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Latches, face counters and registered results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 5; k++) die_q[k] <= '0;
      for (int k = 0; k < 6; k++) cnt_q[k] <= '0;
      cat_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      score    <= '0;
      dice_err <= 1'b0;
`ifdef SCORE_BEST_EN
      eval_q      <= '0;
      run_cat_q   <= '0;
      run_score_q <= '0;
      best_cat    <= '0;
      best_score  <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            die_q[0] <= dice1;
            die_q[1] <= dice2;
            die_q[2] <= dice3;
            die_q[3] <= dice4;
            die_q[4] <= dice5;
            cat_q    <= cat_sel;
            for (int k = 0; k < 6; k++) cnt_q[k] <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
`ifdef SCORE_BEST_EN
            eval_q      <= '0;
            run_cat_q   <= '0;
            run_score_q <= '0;
`endif
          end
        end
        StCount: begin
          idx_q <= idx_q + 3'd1;
          if (cur_face == 3'd0 || cur_face == 3'd7) err_q <= 1'b1;
          for (int k = 0; k < 6; k++) begin
            if (cur_face == 3'(k + 1)) cnt_q[k] <= cnt_q[k] + 3'd1;
          end
        end
        StEval: begin
`ifdef SCORE_BEST_EN
          eval_q <= eval_q + 4'd1;
          if (take) begin
            run_cat_q   <= eval_q;
            run_score_q <= cand;
          end
          if (eval_q == 4'd11) begin
            score    <= sel_score;
            dice_err <= err_q;
            if (err_q) begin
              best_cat   <= '0;
              best_score <= '0;
            end else begin
              best_cat   <= take ? eval_q : run_cat_q;
              best_score <= take ? cand : run_score_q;
            end
          end
`else
          score    <= sel_score;
          dice_err <= err_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_evaluator.sv
// Self-checking bench for score_evaluator: directed cases plus randomized
// evaluations checked against a rule-level scoring model.
module tb_score_evaluator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] dice1, dice2, dice3, dice4, dice5;
  logic [3:0] cat_sel;
  logic       busy, done, dice_err;
  logic [5:0] score;
`ifdef SCORE_BEST_EN
  logic [3:0] best_cat;
  logic [5:0] best_score;
  localparam int Lat = 18;
`else
  localparam int Lat = 7;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  score_evaluator dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dice1     (dice1),
    .dice2     (dice2),
    .dice3     (dice3),
    .dice4     (dice4),
    .dice5     (dice5),
    .cat_sel   (cat_sel),
    .busy      (busy),
    .done      (done),
    .score     (score),
    .dice_err  (dice_err)
`ifdef SCORE_BEST_EN
    ,
    .best_cat  (best_cat),
    .best_score(best_score)
`endif
  );

  function automatic bit model_err(input int d[5]);
    for (int i = 0; i < 5; i++) if (d[i] < 1 || d[i] > 6) return 1'b1;
    return 1'b0;
  endfunction

  // Category scoring straight from the game rules.
  function automatic int model_score(input int d[5], input int cat);
    int cnt[7];
    int sum;
    bit has3, has2, has4, has5;
    bit pr[7];
    if (model_err(d)) return 0;
    for (int f = 0; f < 7; f++) cnt[f] = 0;
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      cnt[d[i]]++;
      sum += d[i];
    end
    has2 = 0; has3 = 0; has4 = 0; has5 = 0;
    for (int f = 1; f <= 6; f++) begin
      pr[f] = cnt[f] > 0;
      if (cnt[f] == 2) has2 = 1;
      if (cnt[f] == 3) has3 = 1;
      if (cnt[f] >= 4) has4 = 1;
      if (cnt[f] == 5) has5 = 1;
    end
    if (cat <= 5) return (cat + 1) * cnt[cat + 1];
    case (cat)
      6:  return sum;
      7:  return has4 ? sum : 0;
      8:  return (has3 && has2) ? sum : 0;
      9:  return ((pr[1] && pr[2] && pr[3] && pr[4]) || (pr[2] && pr[3] && pr[4] && pr[5]) ||
                  (pr[3] && pr[4] && pr[5] && pr[6])) ? 15 : 0;
      10: return ((pr[1] && pr[2] && pr[3] && pr[4] && pr[5]) ||
                  (pr[2] && pr[3] && pr[4] && pr[5] && pr[6])) ? 30 : 0;
      11: return has5 ? 50 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic drive_dice(input int d[5]);
    dice1 = 3'(d[0]);
    dice2 = 3'(d[1]);
    dice3 = 3'(d[2]);
    dice4 = 3'(d[3]);
    dice5 = 3'(d[4]);
  endtask

  task automatic gen_dice(output int d[5]);
    int a, b, s, mode;
    a = $urandom_range(1, 6);
    b = $urandom_range(1, 6);
    s = $urandom_range(1, 2);
    mode = $urandom_range(0, 3);
    for (int i = 0; i < 5; i++) begin
      case (mode)
        0:       d[i] = ($urandom_range(0, 1) == 0) ? a : b;
        1:       d[i] = s + i;
        2:       d[i] = $urandom_range(1, 6);
        default: d[i] = $urandom_range(0, 7);
      endcase
    end
    if (mode == 1 && $urandom_range(0, 1) == 1) d[$urandom_range(0, 4)] = a;
  endtask

  // One evaluation; lat counts cycles from the start cycle (cycle 0) to done.
  task automatic do_eval(input int d[5], input int cat, output int sc, output int er,
                         output int bc, output int bs, output int lat);
    @(negedge clk);
    drive_dice(d);
    cat_sel = 4'(cat);
    start   = 1'b1;
    sc = -1; er = -1; bc = -1; bs = -1; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start   = 1'b0;
        dice1   = 3'($urandom);
        dice2   = 3'($urandom);
        dice3   = 3'($urandom);
        dice4   = 3'($urandom);
        dice5   = 3'($urandom);
        cat_sel = 4'($urandom);
      end
      if (done === 1'b1) begin
        lat = c;
        sc  = int'(score);
        er  = int'(dice_err);
`ifdef SCORE_BEST_EN
        bc = int'(best_cat);
        bs = int'(best_score);
`endif
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    cat_sel = '0;
    dice1 = '0; dice2 = '0; dice3 = '0; dice4 = '0; dice5 = '0;
    #12;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (score !== 6'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_tests++; if (dice_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", dice_err); end
`ifdef SCORE_BEST_EN
    n_tests++; if (best_cat !== 4'd0 || best_score !== 6'd0) begin
      n_fail++; $display("FAIL reset_best: got %0d/%0d expected 0/0", best_cat, best_score); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    int d[5];
    int sc, er, bc, bs, lat;
    d = '{3, 3, 3, 3, 3};
    do_eval(d, 11, sc, er, bc, bs, lat);
    n_tests++; if (lat !== Lat) begin n_fail++; $display("FAIL yacht_latency: got %0d expected %0d", lat, Lat); end
    n_tests++; if (sc !== 50) begin n_fail++; $display("FAIL yacht_score: got %0d expected 50", sc); end
    n_tests++; if (er !== 0) begin n_fail++; $display("FAIL yacht_err: got %0d expected 0", er); end
`ifdef SCORE_BEST_EN
    n_tests++; if (bc !== 11 || bs !== 50) begin
      n_fail++; $display("FAIL yacht_best: got %0d/%0d expected 11/50", bc, bs); end
`endif
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", done, busy); end

    d = '{2, 2, 5, 5, 5};
    do_eval(d, 8, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 19) begin n_fail++; $display("FAIL full_house: got %0d expected 19", sc); end
    do_eval(d, 7, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 0) begin n_fail++; $display("FAIL four_kind_miss: got %0d expected 0", sc); end
    do_eval(d, 4, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 15) begin n_fail++; $display("FAIL fives: got %0d expected 15", sc); end

    d = '{1, 2, 3, 4, 6};
    do_eval(d, 9, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 15) begin n_fail++; $display("FAIL small_straight: got %0d expected 15", sc); end
    do_eval(d, 10, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 0) begin n_fail++; $display("FAIL large_straight_miss: got %0d expected 0", sc); end
`ifdef SCORE_BEST_EN
    n_tests++; if (bc !== 6 || bs !== 16) begin
      n_fail++; $display("FAIL straight_best: got %0d/%0d expected 6/16", bc, bs); end
`endif

    d = '{0, 0, 0, 0, 0};
    do_eval(d, 6, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 0) begin n_fail++; $display("FAIL illegal_score: got %0d expected 0", sc); end
    n_tests++; if (er !== 1) begin n_fail++; $display("FAIL illegal_err: got %0d expected 1", er); end
`ifdef SCORE_BEST_EN
    n_tests++; if (bc !== 0 || bs !== 0) begin
      n_fail++; $display("FAIL illegal_best: got %0d/%0d expected 0/0", bc, bs); end
`endif
    d = '{1, 1, 2, 2, 2};
    do_eval(d, 8, sc, er, bc, bs, lat);
    n_tests++; if (er !== 0) begin n_fail++; $display("FAIL err_cleared: got %0d expected 0", er); end
    n_tests++; if (sc !== 8) begin n_fail++; $display("FAIL full_house_low: got %0d expected 8", sc); end
  endtask

  task automatic test_random();
    int d[5];
    int cat, sc, er, bc, bs, lat, exp_bc, exp_bs, v;
    for (int it = 0; it < 40; it++) begin
      gen_dice(d);
      cat = $urandom_range(0, 15);
      do_eval(d, cat, sc, er, bc, bs, lat);
      n_tests++; if (sc !== model_score(d, cat)) begin n_fail++;
        $display("FAIL rand_score[%0d] dice=%0d%0d%0d%0d%0d cat=%0d: got %0d expected %0d",
                 it, d[0], d[1], d[2], d[3], d[4], cat, sc, model_score(d, cat)); end
      n_tests++; if (er !== int'(model_err(d))) begin n_fail++;
        $display("FAIL rand_err[%0d]: got %0d expected %0d", it, er, model_err(d)); end
      n_tests++; if (lat !== Lat) begin n_fail++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, Lat); end
`ifdef SCORE_BEST_EN
      exp_bc = 0; exp_bs = 0;
      for (int c = 0; c < 12; c++) begin
        v = model_score(d, c);
        if (v > exp_bs) begin exp_bs = v; exp_bc = c; end
      end
      n_tests++; if (bc !== exp_bc || bs !== exp_bs) begin n_fail++;
        $display("FAIL rand_best[%0d]: got %0d/%0d expected %0d/%0d", it, bc, bs, exp_bc, exp_bs); end
`endif
    end
  endtask

  task automatic test_ignored_start();
    int d[5];
    int n_done, sc;
    d = '{2, 3, 4, 5, 6};
    n_done = 0;
    sc = -1;
    @(negedge clk);
    drive_dice(d);
    cat_sel = 4'd13;
    start   = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 2) begin
        start   = 1'b1;
        dice1 = 3'd6; dice2 = 3'd6; dice3 = 3'd6; dice4 = 3'd6; dice5 = 3'd6;
        cat_sel = 4'd11;
      end
      if (c == 3) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        sc = int'(score);
      end
    end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL ignored_start_dones: got %0d expected 1", n_done); end
    n_tests++; if (sc !== 0) begin n_fail++; $display("FAIL cat13_score: got %0d expected 0", sc); end
  endtask

  task automatic test_back_to_back();
    int d[5];
    int first, second, busy_gap, sc2, exp;
    d = '{4, 4, 4, 1, 2};
    exp = model_score(d, 6);
    first = -1; second = -1; busy_gap = -1; sc2 = -1;
    @(negedge clk);
    drive_dice(d);
    cat_sel = 4'd6;
    start   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == Lat + 1) busy_gap = int'(busy);
      if (done === 1'b1) begin
        if (first < 0) first = c;
        else begin
          second = c;
          sc2    = int'(score);
          start  = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    n_tests++; if (first !== Lat) begin n_fail++; $display("FAIL b2b_first: got %0d expected %0d", first, Lat); end
    n_tests++; if (second !== 2 * Lat + 1) begin n_fail++;
      $display("FAIL b2b_second: got %0d expected %0d", second, 2 * Lat + 1); end
    n_tests++; if (busy_gap !== 0) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d expected 0", busy_gap); end
    n_tests++; if (sc2 !== exp) begin n_fail++; $display("FAIL b2b_score: got %0d expected %0d", sc2, exp); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d[5];
    int sc, er, bc, bs, lat, n_done;
    d = '{6, 6, 6, 6, 6};
    do_eval(d, 11, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 50) begin n_fail++; $display("FAIL pre_reset_score: got %0d expected 50", sc); end
    @(negedge clk);
    d = '{1, 2, 3, 4, 5};
    drive_dice(d);
    cat_sel = 4'd10;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_tests++; if (score !== 6'd0) begin n_fail++; $display("FAIL midreset_score: got %0d expected 0", score); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", n_done); end
    do_eval(d, 10, sc, er, bc, bs, lat);
    n_tests++; if (sc !== 30) begin n_fail++; $display("FAIL post_reset_score: got %0d expected 30", sc); end
    n_tests++; if (lat !== Lat) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, Lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
